sync_ram: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request channel and a valid/ready response channel, per-lane write masks, read-before-write responses, out-of-range detection and a hardware clear sequencer. It is the clocked, handshaked successor to our select-strobed RAM and serves as the local data store behind any requester that speaks valid/ready. It sustains one request per cycle with one response per request, in order.

---
 rtl/sync_ram.sv | 115 +++++++++++
 tb/tb_sync_ram.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram.sv
// sync_ram: single-port synchronous RAM behind valid/ready request and
// response channels, with per-lane write masks, read-before-write responses,
// out-of-range detection and a word-per-cycle hardware clear sequencer.
module sync_ram #(
    parameter int unsigned word_size   = 20,
    parameter int unsigned word_amount = 30,
    parameter int unsigned lane_size   = 4,
    localparam int unsigned addr_w     = (word_amount > 1) ? $clog2(word_amount) : 1,
    localparam int unsigned lanes      = word_size / lane_size
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [addr_w-1:0]    req_addr,
    input  logic [word_size-1:0] req_wdata,
    input  logic [lanes-1:0]     req_wmask,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [word_size-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy
);

    // Reject lane geometries that do not tile the word exactly.
    if (lane_size == 0 || (word_size % lane_size) != 0) begin : g_bad_lanes
        $error("sync_ram: word_size must be a non-zero multiple of lane_size");
    end

    localparam logic [addr_w-1:0] last_ptr = addr_w'(word_amount - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t               state;
    logic [addr_w-1:0]    clr_ptr;
    logic [word_size-1:0] mem [word_amount];

    logic                 in_range;
    logic                 accept;
    logic                 stalled;
    logic [word_size-1:0] old_word;
    logic [word_size-1:0] mask_bits;
    logic [word_size-1:0] new_word;

    // Expand the per-lane write enables to a per-bit mask.
    for (genvar i = 0; i < int'(lanes); i++) begin : g_mask
        assign mask_bits[i*lane_size +: lane_size] = {lane_size{req_wmask[i]}};
    end

    assign in_range  = (32'(req_addr) < word_amount);
    assign stalled   = rsp_valid && !rsp_ready;
    assign req_ready = (state == IDLE) && !clr && !stalled;
    assign accept    = req_valid && req_ready;
    assign busy      = (state == CLEAR);
    assign old_word  = in_range ? mem[req_addr] : '0;
    assign new_word  = (old_word & ~mask_bits) | (req_wdata & mask_bits);

    // Control FSM, clear pointer and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                    if (clr_ptr == last_ptr) begin
                        state   <= IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + addr_w'(1);
                    end
                end
                IDLE: begin
                    if (accept) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= old_word;
                        rsp_err   <= !in_range;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                    // A stalled response must drain before a clear may start.
                    if (clr && !stalled) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

    // Storage array: clear writes zeros, accepted in-range writes merge lanes.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (accept && req_op && in_range) begin
            mem[req_addr] <= new_word;
        end
    end

endmodule

// File: tb/tb_sync_ram.sv
// tb_sync_ram: directed vector table plus hand-written sequences for
// backpressure, soft clear and reset abort.
module tb_sync_ram;

    localparam int unsigned WS = 20;
    localparam int unsigned WA = 30;
    localparam int unsigned LS = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned LN = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [AW-1:0] req_addr;
    logic [WS-1:0] req_wdata;
    logic [LN-1:0] req_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [WS-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    sync_ram #(
        .word_size  (WS),
        .word_amount(WA),
        .lane_size  (LS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          op;
        logic [AW-1:0] addr;
        logic [WS-1:0] wdata;
        logic [LN-1:0] wmask;
        logic [WS-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until busy falls, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic add(input logic op, input int addr, input logic [WS-1:0] wd,
                       input logic [LN-1:0] wm, input logic [WS-1:0] er, input logic ee);
        vec_t v;
        v.op = op; v.addr = AW'(addr); v.wdata = wd; v.wmask = wm;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic issue(input logic op, input int addr, input logic [WS-1:0] wd,
                         input logic [LN-1:0] wm);
        req_valid = 1'b1; req_op = op; req_addr = AW'(addr);
        req_wdata = wd; req_wmask = wm;
    endtask

    initial begin
        int n;

        // Vector table: post-clear reads, masked writes, out of range, streaming.
        for (int a = 0; a < 30; a++) add(1'b0, a, 20'h0, 5'h00, 20'h00000, 1'b0);
        add(1'b1, 7, 20'hABCDE, 5'b11111, 20'h00000, 1'b0);
        add(1'b1, 7, 20'h12345, 5'b00101, 20'hABCDE, 1'b0);
        add(1'b0, 7, 20'h0,     5'b00000, 20'hAB3D5, 1'b0);
        add(1'b1, 7, 20'hFFFFF, 5'b00000, 20'hAB3D5, 1'b0);
        add(1'b0, 7, 20'h0,     5'b00000, 20'hAB3D5, 1'b0);
        add(1'b0, 30, 20'h0,    5'b00000, 20'h00000, 1'b1);
        add(1'b1, 31, 20'hFFFFF, 5'b11111, 20'h00000, 1'b1);
        add(1'b0, 0, 20'h0,     5'b00000, 20'h00000, 1'b0);
        for (int a = 0; a < 30; a++)
            add(1'b1, a, WS'(a * 3), 5'b11111, (a == 7) ? 20'hAB3D5 : 20'h00000, 1'b0);
        for (int a = 0; a < 30; a++)
            add(1'b0, a, 20'h0, 5'b00000, WS'(a * 3), 1'b0);

        // Reset values.
        rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        count_busy(n);
        check("clear_cycles", 32'(n), 32'd30);

        // Table-driven vectors, back to back with rsp_ready held high.
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, int'(vecs[i].addr), vecs[i].wdata, vecs[i].wmask);
            #1;
            check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'd1);
            tick();
            check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("vec%0d_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
        end
        req_valid = 1'b0;
        tick();
        check("drain_valid", 32'(rsp_valid), 32'd0);
        check("drain_hold_rdata", 32'(rsp_rdata), 32'h57);

        // Backpressure: read 7 stalled for 5 cycles with next request waiting.
        rsp_ready = 1'b0;
        issue(1'b0, 7, 20'h0, 5'h0);
        tick();
        check("bp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rdata", 32'(rsp_rdata), 32'h15);
        issue(1'b0, 8, 20'h0, 5'h0);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_rdata", 32'(rsp_rdata), 32'h15);
            check("bp_hold_err", 32'(rsp_err), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'd1);
        tick();
        check("bp_next_valid", 32'(rsp_valid), 32'd1);
        check("bp_next_rdata", 32'(rsp_rdata), 32'h18);
        req_valid = 1'b0;
        tick();

        // Soft clear requested while a response is stalled.
        rsp_ready = 1'b0;
        issue(1'b0, 1, 20'h0, 5'h0);
        tick();
        req_valid = 1'b0;
        clr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("sc_req_ready", 32'(req_ready), 32'd0);
            tick();
            check("sc_busy_held", 32'(busy), 32'd0);
            check("sc_valid_held", 32'(rsp_valid), 32'd1);
            check("sc_rdata_held", 32'(rsp_rdata), 32'h3);
        end
        rsp_ready = 1'b1;
        tick();
        clr = 1'b0;
        check("sc_busy_start", 32'(busy), 32'd1);
        check("sc_valid_done", 32'(rsp_valid), 32'd0);

        // Abort the clear at pointer 12 with reset, then a full clear follows.
        for (int c = 0; c < 12; c++) tick();
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        count_busy(n);
        check("abort_clear_cycles", 32'(n), 32'd30);
        issue(1'b0, 29, 20'h0, 5'h0);
        tick();
        check("post_clear_29", 32'(rsp_rdata), 32'd0);
        issue(1'b0, 12, 20'h0, 5'h0);
        tick();
        check("post_clear_12", 32'(rsp_rdata), 32'd0);
        check("post_clear_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
